// File: rtl/mmio_axi_master_if.sv
// AXI4-Lite channels between the MMIO initiator and the peripheral interconnect.
// master: the initiator side; slave: the interconnect side.
interface mmio_axi_master_if #(
    parameter int addr_width = 16
);
    logic [addr_width-1:0] m_axi_awaddr;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    logic [63:0]           m_axi_wdata;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;
    logic [addr_width-1:0] m_axi_araddr;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [63:0]           m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    modport master (
        output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wvalid,
        output m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
        input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
        input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
    );

    modport slave (
        input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wvalid,
        input  m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
        output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
        output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
    );
endinterface

// File: rtl/mmio_axi_master.sv
// Single-outstanding AXI4-Lite initiator for core MMIO loads and stores.
// Optional response timeout with late-response drain: MMIO_AXI_TIMEOUT_EN.
module mmio_axi_master #(
    parameter int addr_width = 16
`ifdef MMIO_AXI_TIMEOUT_EN
  , parameter int timeout = 1024
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [addr_width-1:0] req_addr,
    input  logic [63:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [63:0]           resp_rdata,
    output logic                  resp_err,
    mmio_axi_master_if.master     axi
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RESP
`ifdef MMIO_AXI_TIMEOUT_EN
      , DRAIN
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [63:0]           wdata_q, wdata_d;
    logic [63:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  awv_q, awv_d;
    logic                  wv_q, wv_d;
    logic                  arv_q, arv_d;
    logic                  b_hs, r_hs;
`ifdef MMIO_AXI_TIMEOUT_EN
    logic [31:0]           cnt_q, cnt_d;
    logic                  drain_q, drain_d;
    logic                  write_q, write_d;
`endif
    logic                  unused_resp_lsb;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    assign axi.m_axi_awaddr  = addr_q;
    assign axi.m_axi_araddr  = addr_q;
    assign axi.m_axi_wdata   = wdata_q;
    assign axi.m_axi_awvalid = awv_q;
    assign axi.m_axi_wvalid  = wv_q;
    assign axi.m_axi_arvalid = arv_q;

`ifdef MMIO_AXI_TIMEOUT_EN
    // After a timeout the late B or R is still accepted so the slave can finish.
    assign axi.m_axi_bready = write_q & ((state_q == WRITE) | drain_q);
    assign axi.m_axi_rready = !write_q & ((state_q == READ) | drain_q);
`else
    assign axi.m_axi_bready = (state_q == WRITE);
    assign axi.m_axi_rready = (state_q == READ);
`endif

    assign b_hs = axi.m_axi_bvalid & axi.m_axi_bready;
    assign r_hs = axi.m_axi_rvalid & axi.m_axi_rready;

    // Only the error bit of the response codes matters here.
    assign unused_resp_lsb = axi.m_axi_bresp[0] ^ axi.m_axi_rresp[0];

    // Next-state and datapath: address-channel valids drop after their own handshakes.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        awv_d   = awv_q;
        wv_d    = wv_q;
        arv_d   = arv_q;
`ifdef MMIO_AXI_TIMEOUT_EN
        cnt_d   = cnt_q;
        drain_d = drain_q;
        write_d = write_q;
`endif
        if (awv_q && axi.m_axi_awready) awv_d = 1'b0;
        if (wv_q && axi.m_axi_wready)   wv_d  = 1'b0;
        if (arv_q && axi.m_axi_arready) arv_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
`ifdef MMIO_AXI_TIMEOUT_EN
                    cnt_d   = 32'd0;
                    write_d = req_write;
`endif
                    if (req_write) begin
                        awv_d   = 1'b1;
                        wv_d    = 1'b1;
                        state_d = WRITE;
                    end else begin
                        arv_d   = 1'b1;
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                if (b_hs) begin
                    err_d   = axi.m_axi_bresp[1];
                    rdata_d = 64'd0;
                    state_d = RESP;
                end
`ifdef MMIO_AXI_TIMEOUT_EN
                else if (cnt_q == 32'(timeout - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = 64'd0;
                    drain_d = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
            READ: begin
                if (r_hs) begin
                    err_d   = axi.m_axi_rresp[1];
                    rdata_d = axi.m_axi_rdata;
                    state_d = RESP;
                end
`ifdef MMIO_AXI_TIMEOUT_EN
                else if (cnt_q == 32'(timeout - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = 64'd0;
                    drain_d = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
            RESP: begin
`ifdef MMIO_AXI_TIMEOUT_EN
                if (b_hs || r_hs) drain_d = 1'b0;
                if (resp_ready)
                    state_d = (drain_q && !(b_hs || r_hs)) ? DRAIN : IDLE;
`else
                if (resp_ready) state_d = IDLE;
`endif
            end
`ifdef MMIO_AXI_TIMEOUT_EN
            DRAIN: begin
                if (b_hs || r_hs) begin
                    drain_d = 1'b0;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
            awv_q   <= 1'b0;
            wv_q    <= 1'b0;
            arv_q   <= 1'b0;
`ifdef MMIO_AXI_TIMEOUT_EN
            cnt_q   <= 32'd0;
            drain_q <= 1'b0;
            write_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            awv_q   <= awv_d;
            wv_q    <= wv_d;
            arv_q   <= arv_d;
`ifdef MMIO_AXI_TIMEOUT_EN
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            write_q <= write_d;
`endif
        end
    end

endmodule

// File: tb/tb_mmio_axi_master.sv
// Bench for mmio_axi_master: randomized slave stalls, memory-model scoreboard,
// directed latency, backpressure, reset and timeout scenarios.
module tb_mmio_axi_master;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [63:0]   req_wdata = 64'd0;
    logic          req_ready;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [63:0]   resp_rdata;
    logic          resp_err;

    mmio_axi_master_if #(.addr_width(AW)) axi ();

    mmio_axi_master #(
        .addr_width(AW)
`ifdef MMIO_AXI_TIMEOUT_EN
      , .timeout(8)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .axi        (axi)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Power-on contents of the peripheral space.
    function automatic logic [63:0] init_val(input logic [15:0] a);
        return {a, ~a, a ^ 16'h5a5a, 16'hc0de};
    endfunction

    // ---------------- reference model (scoreboard side) ----------------
    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] model_mem [logic [15:0]];

    // Addresses 0xE000-0xFFFF are unmapped or faulting devices.
    function automatic bit model_err(input logic [15:0] a);
        return a >= 16'he000;
    endfunction

    // ---------------- slave configuration ----------------
    int aw_stall = 0, w_stall = 0, ar_stall = 0, b_dly = 0, r_dly = 0;
    bit no_resp = 0;
    int hold_cfg = 0;

    // ---------------- AXI slave ----------------
    logic [63:0] slave_mem [logic [15:0]];
    int  aw_n, w_n, ar_n, bd_n, rd_n;
    bit  aw_got, w_got, ar_got;
    bit  p_aw, p_w, p_ar, p_b, p_r;
    bit  sv_aw, sv_w, sv_ar;
    logic [15:0] s_waddr, s_raddr, sn_awaddr, sn_araddr;
    logic [63:0] s_wdata, sn_wdata;
    int  b_count = 0, r_count = 0;

    function automatic logic [1:0] resp_code(input logic [15:0] a);
        if (a[15:12] == 4'he) return 2'b10;
        if (a[15:12] == 4'hf) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [63:0] slave_rd(input logic [15:0] a);
        if (slave_mem.exists(a)) return slave_mem[a];
        return init_val(a);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            axi.m_axi_awready = 1'b0;
            axi.m_axi_wready  = 1'b0;
            axi.m_axi_arready = 1'b0;
            axi.m_axi_bvalid  = 1'b0;
            axi.m_axi_bresp   = 2'b00;
            axi.m_axi_rvalid  = 1'b0;
            axi.m_axi_rresp   = 2'b00;
            axi.m_axi_rdata   = 64'd0;
            {aw_got, w_got, ar_got, p_aw, p_w, p_ar, p_b, p_r} = '0;
            {sv_aw, sv_w, sv_ar} = '0;
            {aw_n, w_n, ar_n, bd_n, rd_n} = '0;
        end else begin
            // channels that were valid and not accepted must hold
            if (sv_aw) begin
                if (p_aw) chk("awvalid_drop", axi.m_axi_awvalid, 0);
                else begin
                    chk("awvalid_hold", axi.m_axi_awvalid, 1);
                    chk("awaddr_stable", axi.m_axi_awaddr, sn_awaddr);
                end
            end
            if (sv_w) begin
                if (p_w) chk("wvalid_drop", axi.m_axi_wvalid, 0);
                else begin
                    chk("wvalid_hold", axi.m_axi_wvalid, 1);
                    chk("wdata_stable", axi.m_axi_wdata, sn_wdata);
                end
            end
            if (sv_ar) begin
                if (p_ar) chk("arvalid_drop", axi.m_axi_arvalid, 0);
                else begin
                    chk("arvalid_hold", axi.m_axi_arvalid, 1);
                    chk("araddr_stable", axi.m_axi_araddr, sn_araddr);
                end
            end
            // retire handshakes completed on the last rising edge
            if (p_aw) begin axi.m_axi_awready = 1'b0; aw_got = 1; end
            if (p_w)  begin axi.m_axi_wready  = 1'b0; w_got  = 1; end
            if (p_ar) begin axi.m_axi_arready = 1'b0; ar_got = 1; end
            if (p_b) begin
                axi.m_axi_bvalid = 1'b0;
                {aw_got, w_got} = '0;
                {aw_n, w_n, bd_n} = '0;
                b_count++;
            end
            if (p_r) begin
                axi.m_axi_rvalid = 1'b0;
                ar_got = 0;
                {ar_n, rd_n} = '0;
                r_count++;
            end
            // new ready/valid decisions
            if (axi.m_axi_awvalid && !aw_got && !axi.m_axi_awready) begin
                if (aw_n >= aw_stall) axi.m_axi_awready = 1'b1;
                else aw_n++;
            end
            if (axi.m_axi_wvalid && !w_got && !axi.m_axi_wready) begin
                if (w_n >= w_stall) axi.m_axi_wready = 1'b1;
                else w_n++;
            end
            if (axi.m_axi_arvalid && !ar_got && !axi.m_axi_arready) begin
                if (ar_n >= ar_stall) axi.m_axi_arready = 1'b1;
                else ar_n++;
            end
            if (aw_got && w_got && !axi.m_axi_bvalid && !no_resp) begin
                if (bd_n >= b_dly) begin
                    axi.m_axi_bvalid = 1'b1;
                    axi.m_axi_bresp  = resp_code(s_waddr);
                end else bd_n++;
            end
            if (ar_got && !axi.m_axi_rvalid && !no_resp) begin
                if (rd_n >= r_dly) begin
                    axi.m_axi_rvalid = 1'b1;
                    axi.m_axi_rresp  = resp_code(s_raddr);
                    axi.m_axi_rdata  = axi.m_axi_rresp[1] ? 64'd0
                                                          : slave_rd(s_raddr);
                end else rd_n++;
            end
            // handshakes that complete on the next rising edge
            p_aw = axi.m_axi_awvalid && axi.m_axi_awready;
            p_w  = axi.m_axi_wvalid && axi.m_axi_wready;
            p_ar = axi.m_axi_arvalid && axi.m_axi_arready;
            p_b  = axi.m_axi_bvalid && axi.m_axi_bready;
            p_r  = axi.m_axi_rvalid && axi.m_axi_rready;
            if (p_aw) s_waddr = axi.m_axi_awaddr;
            if (p_w)  s_wdata = axi.m_axi_wdata;
            if (p_ar) s_raddr = axi.m_axi_araddr;
            if (p_b && !axi.m_axi_bresp[1]) slave_mem[s_waddr] = s_wdata;
            sv_aw = axi.m_axi_awvalid; sn_awaddr = axi.m_axi_awaddr;
            sv_w  = axi.m_axi_wvalid;  sn_wdata  = axi.m_axi_wdata;
            sv_ar = axi.m_axi_arvalid; sn_araddr = axi.m_axi_araddr;
        end
    end

    // ---------------- response monitor ----------------
    int          hold_n = 0;
    bit          m_snap = 0;
    logic [63:0] m_rdata;
    logic        m_err;
    exp_t        m_e;

    always @(negedge clk) begin
        if (!rst) begin
            resp_ready = 1'b0;
            hold_n = 0;
            m_snap = 0;
        end else begin
            if (m_snap) begin
                chk("resp_valid_hold", resp_valid, 1);
                chk("resp_rdata_stable", resp_rdata, m_rdata);
                chk("resp_err_stable", resp_err, m_err);
                chk("req_ready_in_resp", req_ready, 0);
            end
            m_snap = 0;
            if (resp_valid) begin
                if (hold_n >= hold_cfg) resp_ready = 1'b1;
                else begin
                    resp_ready = 1'b0;
                    hold_n++;
                end
                if (resp_ready) begin
                    hold_n = 0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_resp: got err=%b rdata=%h required none",
                                 resp_err, resp_rdata);
                    end else begin
                        m_e = exp_q.pop_front();
                        chk("resp_err", resp_err, m_e.err);
                        chk("resp_rdata", resp_rdata, m_e.rdata);
                    end
                end else begin
                    m_snap  = 1;
                    m_rdata = resp_rdata;
                    m_err   = resp_err;
                end
            end else begin
                resp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle();
        int t = 0;
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: got req_ready=0 required 1");
        end
    endtask

    task automatic set_cfg(input int aws, input int ws, input int ars,
                           input int bd, input int rd, input int hold);
        aw_stall = aws; w_stall = ws; ar_stall = ars;
        b_dly = bd; r_dly = rd; hold_cfg = hold;
    endtask

    task automatic issue(input bit w, input logic [15:0] a,
                         input logic [63:0] d);
        exp_t e;
        wait_idle();
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        e.err   = model_err(a);
        e.rdata = 64'd0;
        if (w) begin
            if (!e.err) model_mem[a] = d;
        end else if (!e.err) begin
            e.rdata = model_mem.exists(a) ? model_mem[a] : init_val(a);
        end
        if (no_resp) begin
            e.err   = 1'b1;
            e.rdata = 64'd0;
        end
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, b0, r0;
        logic [15:0] a;
        logic [63:0] d;
        logic [3:0]  rg;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_valids", {axi.m_axi_awvalid, axi.m_axi_wvalid,
                           axi.m_axi_arvalid}, 0);
        chk("rst_readies", {axi.m_axi_bready, axi.m_axi_rready}, 0);
        #2 rst = 1'b1;
        @(negedge clk);

        // zero-wait store
        set_cfg(0, 0, 0, 0, 0, 0);
        issue(1, 16'h0000, 64'h1);
        chk("t1_awvalid_c1", axi.m_axi_awvalid, 1);
        chk("t1_wvalid_c1", axi.m_axi_wvalid, 1);
        chk("t1_awaddr", axi.m_axi_awaddr, 16'h0000);
        chk("t1_wdata", axi.m_axi_wdata, 64'h1);
        @(negedge clk);
        chk("t1_resp_valid_c2", resp_valid, 0);
        @(negedge clk);
        chk("t1_resp_valid_c3", resp_valid, 1);

        // load after a 5-cycle arready stall
        set_cfg(0, 0, 0, 0, 0, 0);
        issue(1, 16'hbff8, 64'h1234);
        wait_idle();
        set_cfg(0, 0, 5, 0, 0, 0);
        issue(0, 16'hbff8, 64'd0);
        n = 0;
        while (axi.m_axi_arvalid && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("t2_arvalid_cycles", 64'(n), 64'd6);

        // W accepted three cycles before AW
        wait_idle();
        set_cfg(3, 0, 0, 0, 0, 0);
        b0 = b_count;
        issue(1, 16'h0040, 64'h0bad_cafe_1357_2468);
        @(negedge clk);
        chk("t3_wvalid_dropped", axi.m_axi_wvalid, 0);
        chk("t3_awvalid_held", axi.m_axi_awvalid, 1);
        wait_idle();
        chk("t3_one_b", 64'(b_count - b0), 64'd1);

        // SLVERR load with the core stalling the response
        set_cfg(0, 0, 0, 0, 0, 4);
        issue(0, 16'he010, 64'd0);
        wait_idle();

        // reset during WRITE
        set_cfg(20, 0, 0, 0, 0, 0);
        issue(1, 16'h7000, 64'h7777);
        @(negedge clk);
        chk("t5_awvalid_pre", axi.m_axi_awvalid, 1);
        #2 rst = 1'b0;
        #1;
        chk("t5_valids_rst", {axi.m_axi_awvalid, axi.m_axi_wvalid,
                              axi.m_axi_arvalid}, 0);
        chk("t5_req_ready_rst", req_ready, 1);
        exp_q.delete();
        model_mem.delete(16'h7000);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("t5_req_ready_after", req_ready, 1);
        set_cfg(0, 0, 0, 0, 0, 0);
        issue(0, 16'h0000, 64'd0);
        wait_idle();

`ifdef MMIO_AXI_TIMEOUT_EN
        // slave silent on a load: timeout, drain, late R discarded
        set_cfg(0, 0, 0, 0, 0, 2);
        no_resp = 1;
        r0 = r_count;
        issue(0, 16'h0100, 64'd0);
        n = 1;
        while (!resp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t6_timeout_cycle", 64'(n), 64'd9);
        n = 0;
        while (resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        no_resp = 0;
        repeat (2) begin
            chk("t6_drain_req_ready", req_ready, 0);
            chk("t6_drain_rready", axi.m_axi_rready, 1);
            @(negedge clk);
        end
        wait_idle();
        chk("t6_late_r_taken", 64'(r_count - r0), 64'd1);
`else
        r0 = r_count;
        chk("t6_r_count", 64'(r_count - r0), 64'd0);
`endif

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0: rg = 4'h0;
                1: rg = 4'h1;
                2: rg = 4'hb;
                3: rg = 4'he;
                default: rg = 4'hf;
            endcase
            a = {rg, 12'($urandom_range(0, 7) * 8)};
            d = {$urandom, $urandom};
            set_cfg($urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 2), $urandom_range(0, 2));
            issue(1'($urandom_range(0, 1)), a, d);
        end
        wait_idle();
        repeat (2) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
